// File: rtl/updown_counter.sv
// Free-running WIDTH-bit up/down counter with a one-cycle wrap pulse; no enable, no backpressure.
// The new count and wrap are both registered and visible right after the sampling clk edge.
module updown_counter #(
    parameter int                WIDTH       = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_1 = '1;
    localparam logic [WIDTH-1:0] ALL_0 = '0;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;

    // Wrap is decided from the pre-step value, so it lines up with the edge that wraps.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (up_down) begin
            count_d = count_q + ONE;
            wrap_d  = (count_q == ALL_1);
        end else begin
            count_d = count_q - ONE;
            wrap_d  = (count_q == ALL_0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RESET_VALUE;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed checks of updown_counter: default 8-bit instance and a WIDTH=4, RESET_VALUE=9 instance.
module tb_updown_counter;

    logic       clk;
    logic       rst_a, ud_a, wrap_a;
    logic [7:0] count_a;
    logic       rst_b, ud_b, wrap_b;
    logic [3:0] count_b;

    int n_cmp = 0;
    int n_err = 0;

    updown_counter u_dut_a (
        .clk     (clk),
        .reset   (rst_a),
        .up_down (ud_a),
        .count   (count_a),
        .wrap    (wrap_a)
    );

    updown_counter #(.WIDTH(4), .RESET_VALUE(4'd9)) u_dut_b (
        .clk     (clk),
        .reset   (rst_b),
        .up_down (ud_b),
        .count   (count_b),
        .wrap    (wrap_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset_a();
        rst_a = 1'b0;
        #1;
        rst_a = 1'b1;
    endtask

    initial begin
        rst_a = 1'b1; ud_a = 1'b1;
        rst_b = 1'b1; ud_b = 1'b1;
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("a_reset_count", 32'(count_a), 32'd0);
        chk("a_reset_wrap",  32'(wrap_a),  32'd0);
        chk("b_reset_count", 32'(count_b), 32'd9);
        chk("b_reset_wrap",  32'(wrap_b),  32'd0);

        // Reset held across edges with up_down=1.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("a_hold_count", 32'(count_a), 32'd0);
            chk("a_hold_wrap",  32'(wrap_a),  32'd0);
        end

        // Release counting down from 0.
        ud_a  = 1'b0;
        rst_a = 1'b1;
        step();
        chk("a_dn_wrap_count", 32'(count_a), 32'd255);
        chk("a_dn_wrap_pulse", 32'(wrap_a),  32'd1);
        step();
        chk("a_dn_254",        32'(count_a), 32'd254);
        chk("a_dn_254_wrap",   32'(wrap_a),  32'd0);
        step();
        chk("a_dn_253",        32'(count_a), 32'd253);
        chk("a_dn_253_wrap",   32'(wrap_a),  32'd0);

        // Full up sweep of 256 edges from 0.
        pulse_reset_a();
        ud_a = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step();
            chk("a_up_sweep_count", 32'(count_a), 32'(i % 256));
            chk("a_up_sweep_wrap",  32'(wrap_a),  (i == 256) ? 32'd1 : 32'd0);
        end

        // Turnaround at 5.
        pulse_reset_a();
        ud_a = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("a_turn_5", 32'(count_a), 32'd5);
        ud_a = 1'b0;
        step();
        chk("a_turn_4", 32'(count_a), 32'd4);
        step();
        chk("a_turn_3", 32'(count_a), 32'd3);
        chk("a_turn_3_wrap", 32'(wrap_a), 32'd0);
        ud_a = 1'b1;
        step();
        chk("a_turn_back_4", 32'(count_a), 32'd4);

        // Asynchronous reset between edges at 0x37.
        pulse_reset_a();
        ud_a = 1'b1;
        for (int i = 0; i < 8'h37; i++) step();
        chk("a_pre_async", 32'(count_a), 32'h37);
        @(negedge clk);
        #1;
        rst_a = 1'b0;
        #1;
        chk("a_async_immediate", 32'(count_a), 32'd0);
        chk("a_async_wrap",      32'(wrap_a),  32'd0);
        step();
        chk("a_async_hold1", 32'(count_a), 32'd0);
        step();
        chk("a_async_hold2", 32'(count_a), 32'd0);
        rst_a = 1'b1;
        step();
        chk("a_first_after_release", 32'(count_a), 32'd1);

        // Narrow instance: reset value 9, count up through wrap, then down through wrap.
        chk("b_still_reset", 32'(count_b), 32'd9);
        rst_b = 1'b1;
        ud_b  = 1'b1;
        for (int v = 10; v <= 16; v++) begin
            step();
            chk("b_up_count", 32'(count_b), 32'(v % 16));
            chk("b_up_wrap",  32'(wrap_b),  (v == 16) ? 32'd1 : 32'd0);
        end
        ud_b = 1'b0;
        step();
        chk("b_dn_wrap_count", 32'(count_b), 32'd15);
        chk("b_dn_wrap_pulse", 32'(wrap_b),  32'd1);
        step();
        chk("b_dn_14",      32'(count_b), 32'd14);
        chk("b_dn_14_wrap", 32'(wrap_b),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits.
REQ-002 Parameter RESET_VALUE, default 0, value loaded into count while reset is asserted.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge except reset.
REQ-004 Port reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-005 Port up_down  input  1  direction select; 1 = count up, 0 = count down.
REQ-006 Port count  output  WIDTH  current counter value, driven directly from a register.
REQ-007 Port wrap  output  1  registered one-cycle pulse marking a wrap-around; may be left unconnected.
REQ-008 The block SHALL use one clock (clk), and reset SHALL be asynchronous and active-low.

Function
REQ-009 While reset=0, the block SHALL hold count=RESET_VALUE (0 by default) and wrap=0, independent of clk and up_down.
REQ-010 On every rising clk edge with reset=1 and up_down=1, the block SHALL set count to count+1, modulo 2^WIDTH.
REQ-011 On every rising clk edge with reset=1 and up_down=0, the block SHALL set count to count-1, modulo 2^WIDTH.
REQ-012 The counter SHALL have no enable; it SHALL change by exactly one on every active edge.
REQ-013 Latency: up_down SHALL be sampled at the rising edge, and the new count SHALL be visible after that same edge (one-cycle update, no pipeline).
REQ-014 Up wrap: count=2^WIDTH-1 (255) with up_down=1 SHALL give count=0 and wrap=1 on the next edge.
REQ-015 Down wrap: count=0 with up_down=0 SHALL give count=2^WIDTH-1 (255) and wrap=1 on the next edge.
REQ-016 On every other active edge, wrap SHALL be 0; wrap SHALL be high for exactly one cycle per wrap event.
REQ-017 Direction change: the step direction SHALL follow the up_down value sampled at each edge, with no dead cycle or extra step.
REQ-018 Arithmetic SHALL be unsigned and WIDTH bits wide; no saturation.
REQ-019 Outputs SHALL never be X or Z after the first reset assertion.

Reset
REQ-020 Assertion of reset (falling edge of reset) SHALL force count=RESET_VALUE and wrap=0 immediately, without waiting for clk.
REQ-021 Reset asserted mid-count SHALL discard the current value; no partial update on a coincident clk edge.
REQ-022 The first count step after release SHALL occur on the first rising clk edge where reset=1 is sampled.
REQ-023 Reset release SHALL be treated as synchronous to clk by the integrator; the block SHALL contain no synchronizer.

Verification
REQ-024 Scenario: hold reset=0 with up_down=1 for 2 edges -> count=0 and wrap=0 throughout.
REQ-025 Scenario: release reset with up_down=0, starting from count=0 -> first edge gives count=255 with wrap=1, then 254, 253 with wrap=0.
REQ-026 Scenario: reset=1, up_down=1 from count=0 for 256 edges -> count goes 1..255 then 0; wrap=1 only on the edge where 255 becomes 0.
REQ-027 Scenario: count up to 5, then set up_down=0 -> next edges give 4, 3; no duplicate value at the turnaround.
REQ-028 Scenario: at count=0x37, drive reset low between clk edges -> count=0 within the same cycle; stays 0 until release.
REQ-029 Scenario: WIDTH=4, RESET_VALUE=9, up count -> reset gives 9; then 10..15, 0 with wrap=1.
